// File: rtl/button_events_pkg.sv
// Shared button codes, event field positions and the event payload type
// used by the button event queue.
package button_events_pkg;

  localparam int unsigned BTN_JOY_DOWN  = 0;
  localparam int unsigned BTN_JOY_UP    = 1;
  localparam int unsigned BTN_JOY_LEFT  = 2;
  localparam int unsigned BTN_JOY_RIGHT = 3;
  localparam int unsigned BTN_JOY_PRESS = 4;
  localparam int unsigned BTN_HOME      = 5;
  localparam int unsigned BTN_MENU      = 6;
  localparam int unsigned BTN_SELECT    = 7;
  localparam int unsigned BTN_START     = 8;
  localparam int unsigned BTN_ACCEPT    = 9;
  localparam int unsigned BTN_BACK      = 10;

  localparam int unsigned EV_CODE_LSB = 0;
  localparam int unsigned EV_CODE_W   = 4;
  localparam int unsigned EV_PRESS    = 4;
  localparam int unsigned EV_REPEAT   = 5;
  localparam int unsigned EV_W        = 6;

  typedef struct packed {
    logic                 rpt;
    logic                 press;
    logic [EV_CODE_W-1:0] code;
  } ev_t;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO with a registered head; count includes the head.
module event_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    mem_cnt_c;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             pop_c, push_c, load_c;

  // Head register refills from storage whenever it is empty or being consumed.
  always_comb begin
    pop_c       = pop_i & out_valid_q;
    push_c      = push_i & ((count_q != CW'(DEPTH)) | pop_c);
    mem_cnt_c   = count_q - CW'(out_valid_q);
    load_c      = (mem_cnt_c != '0) & (~out_valid_q | pop_c);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (load_c) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (pop_c) begin
      out_valid_d = 1'b0;
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = ~out_valid_q;
  assign dout_o  = out_data_q;
  assign count_o = count_q;

endmodule

// File: rtl/button_events.sv
// Turns button level changes into a queue of press/release events.
// Define BUTTON_EVENTS_REPEAT_EN to add joystick auto-repeat.
module button_events
  import button_events_pkg::*;
#(
  parameter int unsigned NBTN         = 11,
  parameter int unsigned FIFO_DEPTH   = 8
`ifdef BUTTON_EVENTS_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = 12000000,
  parameter int unsigned REPEAT_RATE  = 3000000
`endif
) (
  input  logic                          clk,
  input  logic                          resetq,
  input  logic [NBTN-1:0]               btn,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [EV_W-1:0]               ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          stall,
  input  logic                          stall_clr
);

  localparam int unsigned IDX_W = $clog2(NBTN);
`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam int unsigned FW = EV_W;
`else
  localparam int unsigned FW = EV_W - 1;
`endif

  logic [NBTN-1:0]      btn_q;
  logic [NBTN-1:0]      reported_q, reported_d;
  logic [NBTN-1:0]      diff_c;
  logic [IDX_W-1:0]     pick_c;
  logic                 found_c;
  logic                 stall_q, stall_d;
  logic                 pop_c, can_push_c, push_c, edge_push_c;
  logic                 push_press_c;
  logic [EV_CODE_W-1:0] push_code_c;
  logic [FW-1:0]        fifo_din_c;
  logic [FW-1:0]        fifo_dout;
  logic                 fifo_full, fifo_empty;
  ev_t                  ev_c;

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX) + 1;

  logic             rpt_active_q, rpt_active_d;
  logic             rpt_req_q, rpt_req_d;
  logic [1:0]       rpt_code_q, rpt_code_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_pend_c, rpt_push_c, push_rpt_c;

  assign rpt_pend_c = rpt_req_q | (rpt_active_q & (rpt_cnt_q == '0));
`endif

  // Lowest-index pending change wins.
  always_comb begin
    diff_c  = btn_q ^ reported_q;
    found_c = 1'b0;
    pick_c  = '0;
    for (int i = int'(NBTN) - 1; i >= 0; i--) begin
      if (diff_c[i]) begin
        found_c = 1'b1;
        pick_c  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    pop_c        = ev_valid & ev_ready;
    can_push_c   = ~fifo_full | pop_c;
    reported_d   = reported_q;
    stall_d      = stall_q & ~stall_clr;
    push_c       = 1'b0;
    edge_push_c  = 1'b0;
    push_press_c = 1'b0;
    push_code_c  = '0;
`ifdef BUTTON_EVENTS_REPEAT_EN
    rpt_push_c   = 1'b0;
    push_rpt_c   = 1'b0;
`endif
    if (found_c) begin
      if (can_push_c) begin
        push_c             = 1'b1;
        edge_push_c        = 1'b1;
        push_code_c        = EV_CODE_W'(pick_c);
        push_press_c       = btn_q[pick_c];
        reported_d[pick_c] = btn_q[pick_c];
      end else begin
        stall_d = 1'b1;
      end
    end
`ifdef BUTTON_EVENTS_REPEAT_EN
    // Repeats only use idle slots and never count as a stall.
    else if (rpt_pend_c && can_push_c) begin
      push_c       = 1'b1;
      rpt_push_c   = 1'b1;
      push_rpt_c   = 1'b1;
      push_press_c = 1'b1;
      push_code_c  = EV_CODE_W'(rpt_code_q);
    end
    fifo_din_c = {push_rpt_c, push_press_c, push_code_c};
`else
    fifo_din_c = {push_press_c, push_code_c};
`endif
  end

`ifdef BUTTON_EVENTS_REPEAT_EN
  // Tracker follows the most recent direction press until it is released.
  always_comb begin
    rpt_active_d = rpt_active_q;
    rpt_code_d   = rpt_code_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_req_d    = rpt_pend_c & ~rpt_push_c;
    if (rpt_active_q) begin
      rpt_cnt_d = (rpt_cnt_q == '0) ? RPT_W'(REPEAT_RATE - 1) : rpt_cnt_q - RPT_W'(1);
    end
    if (rpt_active_q && !reported_d[IDX_W'(rpt_code_q)]) begin
      rpt_active_d = 1'b0;
      rpt_req_d    = 1'b0;
    end
    if (edge_push_c && push_press_c && (pick_c <= IDX_W'(BTN_JOY_RIGHT))) begin
      rpt_active_d = 1'b1;
      rpt_code_d   = pick_c[1:0];
      rpt_cnt_d    = RPT_W'(REPEAT_DELAY - 1);
      rpt_req_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rpt_active_q <= 1'b0;
      rpt_req_q    <= 1'b0;
      rpt_code_q   <= '0;
      rpt_cnt_q    <= '0;
    end else begin
      rpt_active_q <= rpt_active_d;
      rpt_req_q    <= rpt_req_d;
      rpt_code_q   <= rpt_code_d;
      rpt_cnt_q    <= rpt_cnt_d;
    end
  end

  assign ev_c = ev_t'(fifo_dout);
`else
  assign ev_c = '{rpt: 1'b0, press: fifo_dout[EV_PRESS], code: fifo_dout[EV_CODE_LSB +: EV_CODE_W]};
`endif

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      btn_q      <= '0;
      reported_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      btn_q      <= btn;
      reported_q <= reported_d;
      stall_q    <= stall_d;
    end
  end

  event_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetq  (resetq),
    .push_i  (push_c),
    .din_i   (fifo_din_c),
    .pop_i   (pop_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout),
    .count_o (ev_count)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_data  = ev_c;
  assign stall    = stall_q;

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events; expected events are queued as buttons
// are driven and compared in order as the consumer accepts them.
module tb_button_events;

  localparam int unsigned NBTN  = 11;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic            clk = 1'b0;
  logic            resetq;
  logic [NBTN-1:0] btn;
  logic            ev_valid;
  logic            ev_ready;
  logic [5:0]      ev_data;
  logic [CW-1:0]   ev_count;
  logic            stall;
  logic            stall_clr;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [5:0] sb[$];
  int         pop_cyc[$];
  logic [5:0] mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_events #(
    .NBTN       (NBTN),
    .FIFO_DEPTH (DEPTH)
`ifdef BUTTON_EVENTS_REPEAT_EN
    ,
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (4)
`endif
  ) dut (
    .clk       (clk),
    .resetq    (resetq),
    .btn       (btn),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_data   (ev_data),
    .ev_count  (ev_count),
    .stall     (stall),
    .stall_clr (stall_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [5:0] evp(input int code, input logic press, input logic rpt = 1'b0);
    return {rpt, press, 4'(code)};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Consumer side: each accepted event must match the oldest expectation.
  always @(negedge clk) begin
    if (resetq && ev_valid && ev_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("extra_event", {25'd0, 1'b1, ev_data}, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("event", 32'(ev_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rel_codes[10] = '{0, 1, 2, 3, 4, 5, 7, 8, 9, 10};
    resetq    = 1'b0;
    btn       = '0;
    ev_ready  = 1'b0;
    stall_clr = 1'b0;
    tick(3);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_data",  32'(ev_data),  32'd0);
    check("rst_count", 32'(ev_count), 32'd0);
    check("rst_stall", 32'(stall),    32'd0);
    resetq = 1'b1;
    tick(2);

    // Single press: three-cycle latency, then release.
    btn[9] = 1'b1;
    sb.push_back(evp(9, 1'b1));
    tick(2);
    check("lat_valid_early", 32'(ev_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(ev_valid), 32'd1);
    check("lat_data",  32'(ev_data),  32'h19);
    check("lat_count", 32'(ev_count), 32'd1);
    ev_ready = 1'b1;
    tick(2);
    btn[9] = 1'b0;
    sb.push_back(evp(9, 1'b0));
    tick(6);
    check("t1_drained", 32'(sb.size()), 32'd0);

    // Three simultaneous presses come out one per cycle in index order.
    btn = 11'h421;
    sb.push_back(evp(0, 1'b1));
    sb.push_back(evp(5, 1'b1));
    sb.push_back(evp(10, 1'b1));
    tick(3);
    check("multi_v0", 32'(ev_valid), 32'd1);
    check("multi_d0", 32'(ev_data),  32'h10);
    tick(1);
    check("multi_v1", 32'(ev_valid), 32'd1);
    check("multi_d1", 32'(ev_data),  32'h15);
    tick(1);
    check("multi_v2", 32'(ev_valid), 32'd1);
    check("multi_d2", 32'(ev_data),  32'h1a);
    tick(1);
    btn = '0;
    sb.push_back(evp(0, 1'b0));
    sb.push_back(evp(5, 1'b0));
    sb.push_back(evp(10, 1'b0));
    tick(8);
    check("t2_drained", 32'(sb.size()), 32'd0);
    check("t2_count",   32'(ev_count),  32'd0);

`ifdef BUTTON_EVENTS_REPEAT_EN
    // Held joystick up: press, repeats after 10 then every 4 cycles, release.
    pop_cyc.delete();
    btn[1] = 1'b1;
    sb.push_back(evp(1, 1'b1));
    for (int k = 0; k < 3; k++) sb.push_back(evp(1, 1'b1, 1'b1));
    sb.push_back(evp(1, 1'b0));
    tick(20);
    btn[1] = 1'b0;
    tick(25);
    check("rpt_drained", 32'(sb.size()),      32'd0);
    check("rpt_events",  32'(pop_cyc.size()), 32'd5);
    if (pop_cyc.size() >= 4) begin
      check("rpt_gap_first",  32'(pop_cyc[1] - pop_cyc[0]), 32'd10);
      check("rpt_gap_second", 32'(pop_cyc[2] - pop_cyc[1]), 32'd4);
      check("rpt_gap_third",  32'(pop_cyc[3] - pop_cyc[2]), 32'd4);
    end
`else
    // Fill: nine changes against an eight-deep queue.
    ev_ready = 1'b0;
    btn = 11'h3bf;
    foreach (rel_codes[k]) if (rel_codes[k] != 10) sb.push_back(evp(rel_codes[k], 1'b1));
    tick(14);
    check("full_count", 32'(ev_count), 32'd8);
    check("full_stall", 32'(stall),    32'd1);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    tick(1);
    check("refill_count", 32'(ev_count), 32'd8);
    check("stall_sticky", 32'(stall),    32'd1);
    stall_clr = 1'b1;
    tick(1);
    stall_clr = 1'b0;
    check("stall_cleared", 32'(stall), 32'd0);

    // Full queue, pop and new edge in the same cycle.
    btn[10] = 1'b1;
    sb.push_back(evp(10, 1'b1));
    tick(1);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    tick(1);
    check("pop_push_count", 32'(ev_count), 32'd8);
    check("pop_push_stall", 32'(stall),    32'd0);

    // One-cycle pulse while blocked leaves no event behind.
    btn[6] = 1'b1;
    tick(1);
    btn[6] = 1'b0;
    tick(2);
    check("pulse_stall", 32'(stall), 32'd1);
    stall_clr = 1'b1;
    tick(1);
    stall_clr = 1'b0;
    check("pulse_stall_clr", 32'(stall), 32'd0);
    ev_ready = 1'b1;
    tick(14);
    check("fill_drained", 32'(sb.size()),  32'd0);
    check("fill_count",   32'(ev_count),   32'd0);
    check("fill_valid",   32'(ev_valid),   32'd0);

    btn = '0;
    foreach (rel_codes[k]) sb.push_back(evp(rel_codes[k], 1'b0));
    tick(16);
    check("release_drained", 32'(sb.size()), 32'd0);
`endif

    // Reset mid-operation flushes the queue; held buttons re-report.
    ev_ready = 1'b0;
    btn = 11'h0c0;
    tick(6);
    check("pre_rst_count", 32'(ev_count), 32'd2);
    resetq = 1'b0;
    btn = 11'h030;
    tick(2);
    check("mid_rst_count", 32'(ev_count), 32'd0);
    check("mid_rst_valid", 32'(ev_valid), 32'd0);
    resetq = 1'b1;
    sb.push_back(evp(4, 1'b1));
    sb.push_back(evp(5, 1'b1));
    ev_ready = 1'b1;
    tick(8);
    check("post_rst_drained", 32'(sb.size()), 32'd0);
    btn = '0;
    sb.push_back(evp(4, 1'b0));
    sb.push_back(evp(5, 1'b0));
    tick(8);
    check("final_drained", 32'(sb.size()), 32'd0);
    check("final_count",   32'(ev_count),  32'd0);
    check("final_stall",   32'(stall),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
